// File: rtl/prog_clk_divider.sv
// prog_clk_divider: NCH independent programmable clock dividers. Each channel
// has a shadow configuration that is copied to the active one only at a period boundary.

module prog_clk_divider_ch #(
    parameter int WIDTH    = 26,
    parameter int DIV_INIT = 240000,
    parameter int HI_INIT  = 120000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             wr,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_mode,
    output logic             clk_out,
    output logic             tick,
    output logic             pending
);
    localparam logic [WIDTH-1:0] DIV_RST = WIDTH'(DIV_INIT);
    localparam logic [WIDTH-1:0] HI_RST  = WIDTH'(HI_INIT);

    logic [WIDTH-1:0] div_a, hi_a, div_s, hi_s, cnt;
    logic             mode_a, mode_s;
    logic [WIDTH-1:0] last;
    logic             boundary;
    logic             level;

    // Periods below 2 are clamped to 2, so the last count is at least 1.
    always_comb begin
        last     = (div_a < WIDTH'(2)) ? WIDTH'(1) : div_a - WIDTH'(1);
        boundary = !en || (cnt >= last);
        level    = mode_a ? (cnt == '0) : (cnt < hi_a);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_a   <= DIV_RST;
            hi_a    <= HI_RST;
            mode_a  <= 1'b0;
            div_s   <= DIV_RST;
            hi_s    <= HI_RST;
            mode_s  <= 1'b0;
            cnt     <= '0;
            pending <= 1'b0;
            clk_out <= 1'b0;
            tick    <= 1'b0;
        end else begin
            clk_out <= en && level;
            tick    <= en && (cnt == '0);

            if (boundary) begin
                cnt <= '0;
                if (pending) begin
                    div_a  <= div_s;
                    hi_a   <= hi_s;
                    mode_a <= mode_s;
                end
            end else begin
                cnt <= cnt + WIDTH'(1);
            end

            // A write on a boundary edge lands after the old shadow was consumed.
            if (wr) begin
                div_s   <= wr_div;
                hi_s    <= wr_duty;
                mode_s  <= wr_mode;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end
endmodule

module prog_clk_divider #(
    parameter int NCH      = 4,
    parameter int WIDTH    = 26,
    parameter int DIV_INIT = 240000,
    parameter int HI_INIT  = 120000,
    localparam int CW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [NCH-1:0]   en,
    input  logic             wr_en,
    input  logic [CW-1:0]    wr_ch,
    input  logic [WIDTH-1:0] wr_div,
    input  logic [WIDTH-1:0] wr_duty,
    input  logic             wr_mode,
    output logic [NCH-1:0]   clk_out,
    output logic [NCH-1:0]   tick,
    output logic [NCH-1:0]   pending,
    output logic             wr_err
);
    localparam logic [CW:0] NCH_V = (CW+1)'(NCH);

    logic ch_bad;
    assign ch_bad = ({1'b0, wr_ch} >= NCH_V);

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic wr_hit;
        assign wr_hit = wr_en && (wr_ch == CW'(c));

        prog_clk_divider_ch #(
            .WIDTH   (WIDTH),
            .DIV_INIT(DIV_INIT),
            .HI_INIT (HI_INIT)
        ) u_ch (
            .clk    (clk),
            .rst    (rst),
            .en     (en[c]),
            .wr     (wr_hit),
            .wr_div (wr_div),
            .wr_duty(wr_duty),
            .wr_mode(wr_mode),
            .clk_out(clk_out[c]),
            .tick   (tick[c]),
            .pending(pending[c])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) wr_err <= 1'b0;
        else     wr_err <= wr_en && ch_bad;
    end
endmodule

// File: tb/tb_prog_clk_divider.sv
// Bench for prog_clk_divider: cycle model feeding a scoreboard queue, plus
// directed waveform-shape checks and a 3-channel instance for out-of-range writes.

module tb_prog_clk_divider;
    localparam int NCH = 2, WIDTH = 8, DIV_INIT = 10, HI_INIT = 5;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       en = '0;
    logic             wr_en = 1'b0;
    logic [0:0]       wr_ch = '0;
    logic [WIDTH-1:0] wr_div = '0, wr_duty = '0;
    logic             wr_mode = 1'b0;
    logic [1:0]       clk_out, tick, pending;
    logic             wr_err;

    logic [2:0]       en3 = '0;
    logic             wr_en3 = 1'b0;
    logic [1:0]       wr_ch3 = '0;
    logic [2:0]       clk_out3, tick3, pending3;
    logic             wr_err3;

    always #5 clk = ~clk;

    prog_clk_divider #(.NCH(NCH), .WIDTH(WIDTH), .DIV_INIT(DIV_INIT), .HI_INIT(HI_INIT)) u_dut (
        .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_div(wr_div),
        .wr_duty(wr_duty), .wr_mode(wr_mode), .clk_out(clk_out), .tick(tick),
        .pending(pending), .wr_err(wr_err)
    );

    prog_clk_divider #(.NCH(3), .WIDTH(WIDTH), .DIV_INIT(DIV_INIT), .HI_INIT(HI_INIT)) u_dut3 (
        .clk(clk), .rst(rst), .en(en3), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_div(wr_div),
        .wr_duty(wr_duty), .wr_mode(wr_mode), .clk_out(clk_out3), .tick(tick3),
        .pending(pending3), .wr_err(wr_err3)
    );

    typedef struct {
        logic [1:0] clk_out;
        logic [1:0] tick;
        logic [1:0] pending;
        logic       wr_err;
    } exp_t;

    exp_t sb[$];
    int   n_pass = 0, n_tot = 0;

    int m_cnt[2], m_div[2], m_hi[2], s_div[2], s_hi[2];
    bit m_mode[2], s_mode[2], m_pend[2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_tot++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance the model across one edge, queue its prediction, then compare after the edge.
    task automatic cyc();
        exp_t e, g;
        int   p;
        bit   bnd, hit;
        e.wr_err = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (rst) begin
                m_div[c] = DIV_INIT; m_hi[c] = HI_INIT; m_mode[c] = 0;
                s_div[c] = DIV_INIT; s_hi[c] = HI_INIT; s_mode[c] = 0;
                m_cnt[c] = 0; m_pend[c] = 0;
                e.clk_out[c] = 1'b0; e.tick[c] = 1'b0;
            end else begin
                p = (m_div[c] < 2) ? 2 : m_div[c];
                e.clk_out[c] = en[c] && (m_mode[c] ? (m_cnt[c] == 0) : (m_cnt[c] < m_hi[c]));
                e.tick[c]    = en[c] && (m_cnt[c] == 0);
                bnd = !en[c] || (m_cnt[c] == p - 1);
                hit = wr_en && (int'(wr_ch) == c);
                if (bnd && m_pend[c]) begin
                    m_div[c] = s_div[c]; m_hi[c] = s_hi[c]; m_mode[c] = s_mode[c];
                end
                m_cnt[c] = bnd ? 0 : m_cnt[c] + 1;
                if (bnd) m_pend[c] = 0;
                if (hit) begin
                    s_div[c] = wr_div; s_hi[c] = wr_duty; s_mode[c] = wr_mode; m_pend[c] = 1;
                end
            end
            e.pending[c] = m_pend[c];
        end
        sb.push_back(e);
        @(posedge clk);
        #1;
        g = sb.pop_front();
        chk("clk_out", 32'(clk_out), 32'(g.clk_out));
        chk("tick",    32'(tick),    32'(g.tick));
        chk("pending", 32'(pending), 32'(g.pending));
        chk("wr_err",  32'(wr_err),  32'(g.wr_err));
    endtask

    task automatic run(int n, int ch, output int hi, output int tk);
        hi = 0; tk = 0;
        for (int i = 0; i < n; i++) begin
            cyc();
            hi += int'(clk_out[ch]);
            tk += int'(tick[ch]);
        end
    endtask

    task automatic wr(int ch, int dv, int dt, bit md);
        wr_en = 1'b1; wr_ch = 1'(ch); wr_div = 8'(dv); wr_duty = 8'(dt); wr_mode = md;
        cyc();
        wr_en = 1'b0;
    endtask

    initial begin
        int hi, tk, k;

        // Reset state
        cyc(); cyc();
        chk("rst_clk_out", 32'(clk_out), 0);
        chk("rst_pending", 32'(pending), 0);
        rst = 1'b0;

        // Default 10-cycle period, 5 high
        en = 2'b01;
        run(20, 0, hi, tk);
        chk("s1_high", hi, 10);
        chk("s1_tick", tk, 2);

        // Mid-period write takes effect only after the current period
        run(3, 0, hi, tk);
        wr(0, 4, 1, 1'b0);
        chk("s2_pend_set", 32'(pending[0]), 1);
        run(6, 0, hi, tk);
        chk("s2_old_high", hi, 1);
        chk("s2_pend_clr", 32'(pending[0]), 0);
        run(8, 0, hi, tk);
        chk("s2_high", hi, 2);
        chk("s2_tick", tk, 2);

        // Disabled channel applies each write on the next edge
        wr(1, 6, 3, 1'b0);
        chk("s3_pend1", 32'(pending[1]), 1);
        cyc();
        chk("s3_pend1_clr", 32'(pending[1]), 0);
        wr(1, 8, 2, 1'b0);
        cyc();
        en = 2'b11;
        run(16, 1, hi, tk);
        chk("s3_high", hi, 4);
        chk("s3_tick", tk, 2);

        // Reset mid-period with a pending shadow; write during reset is dropped
        en = 2'b01;
        run(1, 0, hi, tk);
        wr(0, 6, 3, 1'b0);
        chk("s6_pend", 32'(pending[0]), 1);
        rst = 1'b1; wr_en = 1'b1; wr_ch = 1'b1;
        cyc();
        rst = 1'b0; wr_en = 1'b0;
        chk("s6_rst_out", 32'(clk_out), 0);
        chk("s6_rst_pend", 32'(pending), 0);
        run(20, 0, hi, tk);
        chk("s6_high", hi, 10);
        chk("s6_tick", tk, 2);

        // Write on the last count of a period: old period plays out once more
        k = 0;
        while (m_cnt[0] != 9 && k < 12) begin cyc(); k++; end
        chk("s4_align", m_cnt[0], 9);
        wr(0, 3, 1, 1'b1);
        chk("s4_pend", 32'(pending[0]), 1);
        run(10, 0, hi, tk);
        chk("s4_old_high", hi, 5);
        chk("s4_pend_clr", 32'(pending[0]), 0);
        hi = 0;
        for (int i = 0; i < 9; i++) begin
            cyc();
            chk("s4_pulse_eq_tick", 32'(clk_out[0]), 32'(tick[0]));
            hi += int'(clk_out[0]);
        end
        chk("s4_pulses", hi, 3);

        // div=0 behaves as period 2
        wr(0, 0, 1, 1'b0);
        k = 0;
        while (pending[0] && k < 20) begin cyc(); k++; end
        chk("s5_div0_apply", 32'(pending[0]), 0);
        run(4, 0, hi, tk);
        chk("s5_div0_high", hi, 2);
        chk("s5_div0_tick", tk, 2);

        // Out-of-range channel on a 3-channel instance
        wr_en3 = 1'b1; wr_ch3 = 2'd3;
        cyc();
        wr_en3 = 1'b0;
        chk("s5_err_pulse", 32'(wr_err3), 1);
        chk("s5_err_nopend", 32'(pending3), 0);
        cyc();
        chk("s5_err_drop", 32'(wr_err3), 0);
        wr_en3 = 1'b1; wr_ch3 = 2'd2;
        cyc();
        wr_en3 = 1'b0;
        chk("s5_ok_noerr", 32'(wr_err3), 0);
        chk("s5_ok_pend", 32'(pending3), 4);
        cyc();
        chk("s5_ok_applied", 32'(pending3), 0);
        chk("s5_idle_out", 32'(clk_out3), 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
